// File: rtl/mimo_rx_vector_gen.sv
// mimo_rx_vector_gen: computes the real-decomposed received vector Y = R*s for
// one 4x4 16QAM symbol vector, R being 8x8 upper-triangular. Y is emitted
// serially from row 7 down to row 0 using a single multiply-accumulate per cycle.
// Optional feature macro: MIMOGEN_SAT_EN (saturate outputs instead of wrapping).
//
// Handshakes (both ports): a transfer happens on a rising edge where valid and
// ready are both high. The producer holds valid and its payload stable until
// that edge. sym_ready is high only in IDLE; y_valid is high only in OUT, and
// y_data/y_idx/y_last are held until y_ready.
module mimo_rx_vector_gen #(
  parameter int WL   = 16,
  parameter int ACCW = WL + 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r_we,
  input  logic [2:0]    r_row,
  input  logic [2:0]    r_col,
  input  logic [WL-1:0] r_data,
  input  logic          sym_valid,
  output logic          sym_ready,
  input  logic [15:0]   sym_in,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [WL-1:0] y_data,
  output logic [2:0]    y_idx,
  output logic          y_last,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Only the upper triangle is ever written; lower entries stay zero.
  logic signed [WL-1:0] r_q [8][8];
  // Each PAM4 symbol is kept as a sign flag and a "magnitude is 3" flag.
  logic [7:0]             s_neg_q;
  logic [7:0]             s_big_q;
  logic [2:0]             row_q;
  logic [2:0]             col_q;
  logic signed [ACCW-1:0] acc_q;

  logic signed [WL-1:0]   r_sel;
  logic signed [WL+1:0]   r_ext;
  logic signed [WL+1:0]   mag;
  logic signed [WL+1:0]   term;
  logic signed [ACCW-1:0] acc_next;
  logic [WL-1:0]          fmt_val;

`ifdef MIMOGEN_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-WL+1){1'b0}}, {(WL-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-WL+1){1'b1}}, {(WL-1){1'b0}}};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_d   = state_q;
    sym_ready = 1'b0;
    y_valid   = 1'b0;
    y_last    = 1'b0;
    case (state_q)
      IDLE: begin
        sym_ready = 1'b1;
        if (sym_valid) state_d = MAC;
      end
      MAC: begin
        if (col_q == 3'd7) state_d = OUT;
      end
      OUT: begin
        y_valid = 1'b1;
        y_last  = (row_q == 3'd0);
        if (y_ready) state_d = (row_q == 3'd0) ? IDLE : MAC;
      end
      default: state_d = IDLE;
    endcase
  end

  assign y_idx     = row_q;
  assign dbg_state = state_q;

  // One product term R[row][col]*s[col]; x3 is formed as 2R+R, no multiplier.
  always_comb begin
    r_sel    = r_q[row_q][col_q];
    r_ext    = {{2{r_sel[WL-1]}}, r_sel};
    mag      = s_big_q[col_q] ? ((r_ext <<< 1) + r_ext) : r_ext;
    term     = s_neg_q[col_q] ? -mag : mag;
    acc_next = acc_q + ACCW'(term);
  end

  // Output formatting of the completed row sum.
  always_comb begin
`ifdef MIMOGEN_SAT_EN
    if (acc_next > SAT_MAX)      fmt_val = SAT_MAX[WL-1:0];
    else if (acc_next < SAT_MIN) fmt_val = SAT_MIN[WL-1:0];
    else                         fmt_val = acc_next[WL-1:0];
`else
    fmt_val = acc_next[WL-1:0];
`endif
  end

  // R coefficient store: upper-triangle writes accepted only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          r_q[i][j] <= '0;
    end else if (r_we && (state_q == IDLE) && (r_col >= r_row)) begin
      r_q[r_row][r_col] <= r_data;
    end
  end

  // Symbol latch, row/column walk, accumulator and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_neg_q <= '0;
      s_big_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      y_data  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sym_valid) begin
            // PAM4: 00->-3, 01->-1, 11->+1, 10->+3
            for (int j = 0; j < 8; j++) begin
              s_neg_q[j] <= ~sym_in[2*j+1];
              s_big_q[j] <= ~sym_in[2*j];
            end
            row_q <= 3'd7;
            col_q <= 3'd7;
            acc_q <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_next;
          if (col_q == 3'd7) y_data <= fmt_val;
          else               col_q  <= col_q + 3'd1;
        end
        OUT: begin
          // Next row starts on its diagonal element.
          if (y_ready && (row_q != 3'd0)) begin
            row_q <= row_q - 3'd1;
            col_q <= row_q - 3'd1;
            acc_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mimo_rx_vector_gen.sv
// tb_mimo_rx_vector_gen: scoreboard bench for mimo_rx_vector_gen. Expected Y
// elements are computed from an integer R model when a vector is accepted and
// compared in order as the DUT hands them out.
module tb_mimo_rx_vector_gen;
  localparam int WL = 16;
  localparam int EW = WL + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          r_we;
  logic [2:0]    r_row;
  logic [2:0]    r_col;
  logic [WL-1:0] r_data;
  logic          sym_valid;
  logic          sym_ready;
  logic [15:0]   sym_in;
  logic          y_valid;
  logic          y_ready;
  logic [WL-1:0] y_data;
  logic [2:0]    y_idx;
  logic          y_last;
  logic [1:0]    dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [EW-1:0] exp_q[$];
  int r_model [8][8];
  int cyc = 0;
  int acc_cyc;
  int first_lat;
  int last_lat;
  logic [WL-1:0] last_y;

  mimo_rx_vector_gen #(.WL(WL)) dut (
    .clk(clk), .rst(rst), .r_we(r_we), .r_row(r_row), .r_col(r_col),
    .r_data(r_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_in(sym_in), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_idx(y_idx), .y_last(y_last), .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pam(input logic [1:0] b);
    case (b)
      2'b00:   return -3;
      2'b01:   return -1;
      2'b11:   return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic [WL-1:0] fmt(input longint v);
    logic [63:0] u;
`ifdef MIMOGEN_SAT_EN
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    u = v;
    return u[WL-1:0];
  endfunction

  // ---- driver tasks ----
  task automatic do_reset(input int n);
    rst = 1'b1; r_we = 1'b0; sym_valid = 1'b0; y_ready = 1'b1;
    r_row = '0; r_col = '0; r_data = '0; sym_in = '0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        r_model[i][j] = 0;
    exp_q.delete();
  endtask

  task automatic write_r(input int row, input int col, input int data);
    r_we = 1'b1; r_row = 3'(row); r_col = 3'(col); r_data = 16'(data);
    @(posedge clk); #1;
    r_we = 1'b0;
    if (col >= row) r_model[row][col] = int'($signed(16'(data)));
  endtask

  task automatic load_upper_ones();
    for (int i = 0; i < 8; i++)
      for (int j = i; j < 8; j++)
        write_r(i, j, 1);
  endtask

  task automatic push_expected(input logic [15:0] sym);
    for (int i = 7; i >= 0; i--) begin
      longint sum = 0;
      for (int j = i; j < 8; j++)
        sum += longint'(r_model[i][j]) * longint'(pam(sym[2*j +: 2]));
      exp_q.push_back({3'(i), fmt(sum)});
    end
  endtask

  task automatic send_vector(input logic [15:0] sym, input bit we,
                             input int wr, input int wc, input int wd);
    int g = 0;
    sym_in = sym; sym_valid = 1'b1;
    if (we) begin
      r_we = 1'b1; r_row = 3'(wr); r_col = 3'(wc); r_data = 16'(wd);
    end
    while (!sym_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 100) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout: sym_ready=%0b required 1", sym_ready);
    end
    if (we && wc >= wr) r_model[wr][wc] = int'($signed(16'(wd)));
    acc_cyc = cyc;
    push_expected(sym);
    @(posedge clk); #1;
    sym_valid = 1'b0; r_we = 1'b0;
  endtask

  // Consume n outputs, optionally holding y_ready low for stall_len cycles
  // when the element with index stall_idx first appears.
  task automatic collect(input int n, input int stall_idx, input int stall_len);
    int got = 0;
    int guard = 0;
    bit stalled = 0;
    bit seen = 0;
    logic [EW-1:0] e;
    y_ready = 1'b1;
    first_lat = -1; last_lat = -1;
    while (got < n && guard < 400) begin
      if (y_valid) begin
        if (!seen) begin first_lat = cyc - acc_cyc; seen = 1; end
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL unexpected_output: y_idx=%0d y_data=%0d, none required", y_idx, y_data);
          got = n;
        end else begin
          if (int'(y_idx) == stall_idx && !stalled && stall_len > 0) begin
            e = exp_q[0];
            y_ready = 1'b0; stalled = 1;
            repeat (stall_len) begin
              @(posedge clk); #1;
              tests_run++;
              if (y_valid !== 1'b1 || y_data !== e[WL-1:0] || y_idx !== e[EW-1:WL] ||
                  dbg_state !== 2'd2) begin
                tests_failed++;
                $display("FAIL stall_hold: valid=%0b data=%0d idx=%0d st=%0d required 1/%0d/%0d/2",
                         y_valid, $signed(y_data), y_idx, dbg_state,
                         $signed(e[WL-1:0]), e[EW-1:WL]);
              end
            end
            y_ready = 1'b1;
          end
          e = exp_q.pop_front();
          tests_run++;
          if (y_data !== e[WL-1:0]) begin
            tests_failed++;
            $display("FAIL y_data[%0d]: got %0d required %0d", e[EW-1:WL],
                     $signed(y_data), $signed(e[WL-1:0]));
          end
          tests_run++;
          if (y_idx !== e[EW-1:WL]) begin
            tests_failed++;
            $display("FAIL y_idx: got %0d required %0d", y_idx, e[EW-1:WL]);
          end
          tests_run++;
          if (y_last !== (e[EW-1:WL] == 3'd0)) begin
            tests_failed++;
            $display("FAIL y_last[%0d]: got %0b required %0b", e[EW-1:WL], y_last,
                     (e[EW-1:WL] == 3'd0));
          end
          if (y_last) last_lat = cyc - acc_cyc;
          last_y = y_data;
          got++;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    if (got < n) begin
      tests_run++; tests_failed++;
      $display("FAIL collect_timeout: got %0d outputs required %0d", got, n);
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    do_reset(3);
    tests_run++;
    if (sym_ready !== 1'b1 || y_valid !== 1'b0 || y_data !== 16'd0 ||
        y_idx !== 3'd0 || y_last !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b data=%0d idx=%0d last=%0b st=%0d required 1/0/0/0/0/0",
               sym_ready, y_valid, y_data, y_idx, y_last, dbg_state);
    end
  endtask

  task automatic test_diag();
    do_reset(2);
    for (int i = 0; i < 8; i++) write_r(i, i, 256);
    send_vector(16'h0000, 0, 0, 0, 0);
    collect(8, -1, 0);
    tests_run++;
    if (last_y !== 16'hFD00) begin
      tests_failed++;
      $display("FAIL diag_y0: got %0d required -768", $signed(last_y));
    end
  endtask

  task automatic test_upper_ones();
    do_reset(2);
    load_upper_ones();
    send_vector(16'hAAAA, 0, 0, 0, 0);
    collect(8, -1, 0);
    tests_run++;
    if (first_lat != 2) begin
      tests_failed++;
      $display("FAIL first_latency: got %0d required 2", first_lat);
    end
    tests_run++;
    if (last_lat != 44) begin
      tests_failed++;
      $display("FAIL vector_cycles: got %0d required 44", last_lat);
    end
    tests_run++;
    if (last_y !== 16'd24) begin
      tests_failed++;
      $display("FAIL ones_y0: got %0d required 24", $signed(last_y));
    end
  endtask

  task automatic test_backpressure();
    send_vector(16'hAAAA, 0, 0, 0, 0);
    collect(8, 5, 5);
  endtask

  task automatic test_write_ignored();
    write_r(3, 1, 1234);
    send_vector(16'hAAAA, 0, 0, 0, 0);
    // Upper-triangle write while the MAC is running must not land.
    r_we = 1'b1; r_row = 3'd0; r_col = 3'd7; r_data = 16'd777;
    @(posedge clk); #1;
    r_we = 1'b0;
    collect(8, -1, 0);
    send_vector(16'hAAAA, 0, 0, 0, 0);
    collect(8, -1, 0);
    // Write in the accept cycle is used by the vector just accepted.
    send_vector(16'hAAAA, 1, 7, 7, 5);
    collect(8, -1, 0);
    write_r(7, 7, 1);
  endtask

  task automatic test_saturation();
    do_reset(2);
    for (int j = 0; j < 8; j++) write_r(0, j, 32767);
    send_vector(16'hAAAA, 0, 0, 0, 0);
    collect(8, -1, 0);
    tests_run++;
`ifdef MIMOGEN_SAT_EN
    if (last_y !== 16'h7FFF) begin
      tests_failed++;
      $display("FAIL sat_y0: got %0d required 32767", $signed(last_y));
    end
`else
    if (last_y !== 16'hFFE8) begin
      tests_failed++;
      $display("FAIL wrap_y0: got %0d required -24", $signed(last_y));
    end
`endif
  endtask

  task automatic test_reset_mid();
    int seen_valid = 0;
    do_reset(2);
    load_upper_ones();
    send_vector(16'hAAAA, 0, 0, 0, 0);
    collect(3, -1, 0);
    tests_run++;
    if (dbg_state !== 2'd1 || y_idx !== 3'd4) begin
      tests_failed++;
      $display("FAIL mid_position: st=%0d idx=%0d required 1/4", dbg_state, y_idx);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (dbg_state !== 2'd0 || y_valid !== 1'b0 || sym_ready !== 1'b1 ||
        y_data !== 16'd0 || y_idx !== 3'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: st=%0d vld=%0b rdy=%0b data=%0d idx=%0d required 0/0/1/0/0",
               dbg_state, y_valid, sym_ready, y_data, y_idx);
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        r_model[i][j] = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (y_valid) seen_valid++;
    end
    tests_run++;
    if (seen_valid != 0) begin
      tests_failed++;
      $display("FAIL partial_output: got %0d valid cycles required 0", seen_valid);
    end
    // R was cleared: every row sums to zero.
    send_vector(16'hAAAA, 0, 0, 0, 0);
    collect(8, -1, 0);
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    for (int i = 0; i < 8; i++)
      for (int j = i; j < 8; j++)
        write_r(i, j, int'($urandom_range(0, 65535)));
    for (int v = 0; v < 4; v++) begin
      send_vector(16'($urandom_range(0, 65535)), 0, 0, 0, 0);
      collect(8, -1, 0);
    end
  endtask

  // ---- sequence and report ----
  initial begin
    test_reset();
    test_diag();
    test_upper_ones();
    test_backpressure();
    test_write_ignored();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
